// File: rtl/uart_setpoint_decoder_pkg.sv
// Shared types and constants for the UART setpoint frame decoder.
// Frame on the wire: SOF, CH, DH, DL, CHK with CHK = CH ^ DH ^ DL.
package uart_setpoint_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_CH,
    GET_DH,
    GET_DL,
    GET_CHK,
    RESP
  } state_t;

  localparam logic [7:0] SOF       = 8'hA5;
  localparam logic [7:0] ACK       = 8'h06;
  localparam logic [7:0] NAK       = 8'h15;
  localparam int         FRAME_LEN = 5;

  function automatic logic [7:0] frame_chk(input logic [7:0] ch,
                                           input logic [7:0] dh,
                                           input logic [7:0] dl);
    return ch ^ dh ^ dl;
  endfunction

endpackage

// File: rtl/uart_setpoint_decoder_if.sv
// Byte channels between the UART core (master) and the setpoint decoder (slave).
// Handshake: a byte moves on any clock edge where valid && ready are both high; valid holds its byte stable until then.
interface uart_setpoint_decoder_if;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] rx_bits;
  logic       rx_error;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_bits;

  modport master (
    output rx_valid, rx_bits, rx_error, tx_ready,
    input  rx_ready, tx_valid, tx_bits
  );

  modport slave (
    input  rx_valid, rx_bits, rx_error, tx_ready,
    output rx_ready, tx_valid, tx_bits
  );
endinterface

// File: rtl/uart_setpoint_decoder_timeout.sv
// Inter-byte timeout: loaded on every accepted byte, counts down while a frame is open.
// expired pulses on the cycle the count sits at zero, i.e. LIMIT idle cycles after the last byte.
module sp_timeout_counter #(
  parameter int LIMIT = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int             W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0]   LOAD = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)              cnt_q <= '0;
    else if (clear)         cnt_q <= LOAD;
    else if (!enable)       cnt_q <= '0;
    else if (cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
  end

  assign expired = enable && !clear && (cnt_q == '0);

endmodule

// File: rtl/uart_setpoint_decoder.sv
// Parses 5-byte setpoint frames from the UART RX channel, updates the DAC setpoint bank
// with a one-cycle strobe, and answers each completed or aborted frame with ACK/NAK.
module uart_setpoint_decoder
  import uart_setpoint_pkg::*;
#(
  parameter int NUM_CH      = 12,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                     clock,
  input  logic                     reset,
  uart_setpoint_decoder_if.slave   bus,
  output logic [NUM_CH*DATA_W-1:0] sp_data,
  output logic [NUM_CH-1:0]        sp_update,
  output logic [15:0]              frame_err_cnt,
  output state_t                   state_dbg
);

  localparam logic [7:0] NUM_CH_B = 8'(NUM_CH);

  state_t                    state_q, state_d;
  logic [7:0]                ch_q, ch_d, dh_q, dh_d, dl_q, dl_d;
  logic [7:0]                tx_bits_q, tx_bits_d;
  logic [NUM_CH*DATA_W-1:0]  sp_data_q, sp_data_d;
  logic [NUM_CH-1:0]         sp_update_q, sp_update_d;
  logic [15:0]               err_q, err_d;
  logic                      err_inc, byte_ok, in_frame, tmo_expired;

  assign bus.rx_ready  = (state_q != RESP);
  assign bus.tx_valid  = (state_q == RESP);
  assign bus.tx_bits   = tx_bits_q;
  assign sp_data       = sp_data_q;
  assign sp_update     = sp_update_q;
  assign frame_err_cnt = err_q;
  assign state_dbg     = state_q;

  // An errored byte is never consumed, even though rx_ready is high.
  assign byte_ok  = bus.rx_valid && bus.rx_ready && !bus.rx_error;
  assign in_frame = (state_q == GET_CH) || (state_q == GET_DH) ||
                    (state_q == GET_DL) || (state_q == GET_CHK);

  sp_timeout_counter #(.LIMIT(TIMEOUT_CYC)) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (byte_ok),
    .enable  (in_frame),
    .expired (tmo_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      dh_q        <= '0;
      dl_q        <= '0;
      tx_bits_q   <= '0;
      sp_data_q   <= '0;
      sp_update_q <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      dh_q        <= dh_d;
      dl_q        <= dl_d;
      tx_bits_q   <= tx_bits_d;
      sp_data_q   <= sp_data_d;
      sp_update_q <= sp_update_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    dh_d        = dh_q;
    dl_d        = dl_q;
    tx_bits_d   = tx_bits_q;
    sp_data_d   = sp_data_q;
    sp_update_d = '0;
    err_inc     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.rx_error)                             err_inc = 1'b1;
        else if (byte_ok && (bus.rx_bits == SOF))     state_d = GET_CH;
      end
      GET_CH, GET_DH, GET_DL, GET_CHK: begin
        if (bus.rx_error || tmo_expired) begin
          tx_bits_d = NAK;
          err_inc   = 1'b1;
          state_d   = RESP;
        end else if (byte_ok) begin
          case (state_q)
            GET_CH: begin ch_d = bus.rx_bits; state_d = GET_DH; end
            GET_DH: begin dh_d = bus.rx_bits; state_d = GET_DL; end
            GET_DL: begin dl_d = bus.rx_bits; state_d = GET_CHK; end
            default: begin
              if ((bus.rx_bits == frame_chk(ch_q, dh_q, dl_q)) && (ch_q < NUM_CH_B)) begin
                for (int k = 0; k < NUM_CH; k++) begin
                  if (ch_q == 8'(k)) begin
                    sp_update_d[k]                  = 1'b1;
                    sp_data_d[k*DATA_W +: DATA_W]   = {dh_q, dl_q};
                  end
                end
                tx_bits_d = ACK;
              end else begin
                tx_bits_d = NAK;
                err_inc   = 1'b1;
              end
              state_d = RESP;
            end
          endcase
        end
      end
      RESP: begin
        if (bus.rx_error) err_inc = 1'b1;
        if (bus.tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    err_d = (err_inc && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;
  end

endmodule

// File: tb/tb_uart_setpoint_decoder.sv
// Bench for uart_setpoint_decoder: frame vector table, hand-built corner sequences,
// and random frames scored against a frame-level reference model.
module tb_uart_setpoint_decoder;
  import uart_setpoint_pkg::*;

  localparam int NUM_CH = 12;
  localparam int DATA_W = 16;
  localparam int TMO    = 64;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [NUM_CH*DATA_W-1:0] sp_data;
  logic [NUM_CH-1:0]        sp_update;
  logic [15:0]              frame_err_cnt;
  state_t                   state_dbg;

  uart_setpoint_decoder_if bus ();

  uart_setpoint_decoder #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .sp_data       (sp_data),
    .sp_update     (sp_update),
    .frame_err_cnt (frame_err_cnt),
    .state_dbg     (state_dbg)
  );

  always #5 clock = ~clock;

  // Reference model state and scoreboard queues
  logic [7:0]        exp_q[$];
  logic [NUM_CH-1:0] upd_q[$];
  logic [15:0]       exp_sp[NUM_CH];
  int                exp_err;
  int                n_checks = 0;
  int                n_fail   = 0;

  typedef struct {
    logic [39:0] frame;
    logic [7:0]  exp_tx;
    int          exp_ch;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: outcome depends only on checksum and channel range.
  task automatic model_frame(input logic [7:0] ch, input logic [7:0] dh,
                             input logic [7:0] dl, input logic [7:0] chk);
    logic [NUM_CH-1:0] m;
    if ((chk == (ch ^ dh ^ dl)) && (int'(ch) < NUM_CH)) begin
      exp_q.push_back(8'h06);
      m = '0;
      m[ch] = 1'b1;
      upd_q.push_back(m);
      exp_sp[ch] = {dh, dl};
    end else begin
      exp_q.push_back(8'h15);
      exp_err++;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) exp_sp[k] = '0;
    exp_err = 0;
    exp_q.delete();
    upd_q.delete();
  endtask

  // Drivers change inputs 1 time unit after the rising edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(posedge clock); #1;
    bus.rx_valid = 1'b1;
    bus.rx_bits  = b;
    while (!bus.rx_ready && n < 1000) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 1000) check("rx_accept_timeout", 32'(n), 32'd0);
    @(posedge clock); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int i = FRAME_LEN - 1; i >= 0; i--) send_byte(f[i*8 +: 8]);
  endtask

  task automatic pulse_error();
    @(posedge clock); #1;
    bus.rx_error = 1'b1;
    @(posedge clock); #1;
    bus.rx_error = 1'b0;
  endtask

  // Monitor: every TX handshake and every setpoint strobe is scored against the model queues.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.tx_valid && bus.tx_ready) begin
        logic [7:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        check("tx_resp", 32'(bus.tx_bits), 32'(e));
      end
      if (sp_update != '0) begin
        logic [NUM_CH-1:0] u;
        u = (upd_q.size() > 0) ? upd_q.pop_front() : '0;
        check("sp_update_onehot", 32'($countones(sp_update)), 32'd1);
        check("sp_update_chan", 32'(sp_update), 32'(u));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        saw_tx, stable;
    logic [7:0]  ch, dh, dl, chk, g;
    logic [NUM_CH-1:0] m;

    vecs[0] = '{frame: 40'hA503123425, exp_tx: 8'h06, exp_ch: 3};
    vecs[1] = '{frame: 40'hA503123400, exp_tx: 8'h15, exp_ch: -1};
    vecs[2] = '{frame: 40'hA50C00010D, exp_tx: 8'h15, exp_ch: -1};
    vecs[3] = '{frame: 40'hA500ABCD66, exp_tx: 8'h06, exp_ch: 0};
    vecs[4] = '{frame: 40'hA50BFFFF0B, exp_tx: 8'h06, exp_ch: 11};
    vecs[5] = '{frame: 40'hA5FF0000FF, exp_tx: 8'h15, exp_ch: -1};
    vecs[6] = '{frame: 40'hA503123425, exp_tx: 8'h06, exp_ch: 3};
    vecs[7] = '{frame: 40'hA5A50000A5, exp_tx: 8'h15, exp_ch: -1};

    // Clock/reset
    bus.rx_valid = 1'b0;
    bus.rx_bits  = 8'h00;
    bus.rx_error = 1'b0;
    bus.tx_ready = 1'b1;
    reset        = 1'b1;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("rst_rx_ready",  32'(bus.rx_ready), 32'd1);
    check("rst_tx_valid",  32'(bus.tx_valid), 32'd0);
    check("rst_tx_bits",   32'(bus.tx_bits), 32'd0);
    check("rst_sp_data",   32'(|sp_data), 32'd0);
    check("rst_sp_update", 32'(sp_update), 32'd0);
    check("rst_err_cnt",   32'(frame_err_cnt), 32'd0);
    check("rst_state",     32'(state_dbg), 32'(IDLE));
    reset = 1'b0;

    // Table-driven frames, response and strobe visible on the CHK acceptance edge
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].exp_tx == 8'h06) begin
        exp_q.push_back(8'h06);
        m = '0;
        m[vecs[i].exp_ch] = 1'b1;
        upd_q.push_back(m);
        exp_sp[vecs[i].exp_ch] = vecs[i].frame[23:8];
      end else begin
        exp_q.push_back(8'h15);
        m = '0;
        exp_err++;
      end
      send_frame(vecs[i].frame);
      check("vec_tx_valid",  32'(bus.tx_valid), 32'd1);
      check("vec_tx_bits",   32'(bus.tx_bits), 32'(vecs[i].exp_tx));
      check("vec_sp_update", 32'(sp_update), 32'(m));
      check("vec_err_cnt",   32'(frame_err_cnt), 32'(exp_err));
      if (vecs[i].exp_ch >= 0)
        check("vec_sp_data", 32'(sp_data[vecs[i].exp_ch*DATA_W +: DATA_W]), 32'(vecs[i].frame[23:8]));
      @(posedge clock); #1;
      check("vec_strobe_1cyc", 32'(sp_update), 32'd0);
      check("vec_tx_1cyc",     32'(bus.tx_valid), 32'd0);
    end

    // Stray byte dropped, then a stalled frame times out after exactly TMO idle cycles
    send_byte(8'h55);
    check("drop_state",   32'(state_dbg), 32'(IDLE));
    check("drop_err_cnt", 32'(frame_err_cnt), 32'(exp_err));
    exp_q.push_back(8'h15);
    exp_err++;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'hAB); send_byte(8'hCD);
    saw_tx = 1'b0;
    repeat (TMO - 1) begin
      @(posedge clock); #1;
      if (bus.tx_valid) saw_tx = 1'b1;
    end
    check("tmo_not_early", 32'(saw_tx), 32'd0);
    @(posedge clock); #1;
    check("tmo_tx_valid", 32'(bus.tx_valid), 32'd1);
    check("tmo_tx_bits",  32'(bus.tx_bits), 32'h15);
    check("tmo_err_cnt",  32'(frame_err_cnt), 32'(exp_err));
    model_frame(8'h00, 8'hAB, 8'hCD, 8'h66);
    send_frame(40'hA500ABCD66);
    check("tmo_recover_tx", 32'(bus.tx_bits), 32'h06);
    check("tmo_recover_sp", 32'(sp_data[0 +: DATA_W]), 32'hABCD);

    // TX back-pressure for 50 cycles, with an rx_error landing inside RESP
    @(posedge clock); #1;
    bus.tx_ready = 1'b0;
    model_frame(8'h07, 8'h55, 8'hAA, 8'hF8);
    send_frame(40'hA50755AAF8);
    stable = 1'b1;
    for (int j = 0; j < 50; j++) begin
      bus.rx_error = (j == 25);
      @(posedge clock); #1;
      if (!(bus.tx_valid && bus.tx_bits == 8'h06 && !bus.rx_ready)) stable = 1'b0;
    end
    bus.rx_error = 1'b0;
    exp_err++;
    check("stall_stable",  32'(stable), 32'd1);
    check("stall_err_cnt", 32'(frame_err_cnt), 32'(exp_err));
    bus.tx_ready = 1'b1;
    @(posedge clock); #1;
    check("stall_release", 32'(bus.tx_valid), 32'd0);
    check("stall_sp_data", 32'(sp_data[7*DATA_W +: DATA_W]), 32'h55AA);

    // rx_error mid-frame aborts with NAK
    send_byte(8'hA5); send_byte(8'h02);
    exp_q.push_back(8'h15);
    exp_err++;
    @(posedge clock); #1;
    bus.rx_error = 1'b1;
    @(posedge clock); #1;
    bus.rx_error = 1'b0;
    check("abort_tx_valid", 32'(bus.tx_valid), 32'd1);
    check("abort_tx_bits",  32'(bus.tx_bits), 32'h15);
    check("abort_err_cnt",  32'(frame_err_cnt), 32'(exp_err));

    // rx_error with a coincident SOF in IDLE: byte discarded, count only
    repeat (2) @(posedge clock);
    #1;
    bus.rx_valid = 1'b1;
    bus.rx_bits  = 8'hA5;
    bus.rx_error = 1'b1;
    @(posedge clock); #1;
    bus.rx_valid = 1'b0;
    bus.rx_error = 1'b0;
    exp_err++;
    check("errsof_state",   32'(state_dbg), 32'(IDLE));
    check("errsof_err_cnt", 32'(frame_err_cnt), 32'(exp_err));

    // Random frames with occasional leading garbage, scored by the model
    for (int f = 0; f < 40; f++) begin
      for (int gi = 0; gi < int'($urandom_range(0, 2)); gi++) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h00;
        send_byte(g);
      end
      ch  = 8'($urandom_range(0, 15));
      dh  = 8'($urandom_range(0, 255));
      dl  = 8'($urandom_range(0, 255));
      chk = ch ^ dh ^ dl;
      if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      model_frame(ch, dh, dl, chk);
      send_frame({8'hA5, ch, dh, dl, chk});
      check("rand_err_cnt", 32'(frame_err_cnt), 32'(exp_err));
    end
    @(posedge clock); #1;
    for (int k = 0; k < NUM_CH; k++)
      check("bank_sp_data", 32'(sp_data[k*DATA_W +: DATA_W]), 32'(exp_sp[k]));

    // Reset mid-frame, then a clean frame, then rx_error pulses in IDLE
    send_byte(8'hA5); send_byte(8'h05);
    reset = 1'b1;
    model_reset();
    #1;
    check("midrst_state",     32'(state_dbg), 32'(IDLE));
    check("midrst_rx_ready",  32'(bus.rx_ready), 32'd1);
    check("midrst_tx_valid",  32'(bus.tx_valid), 32'd0);
    check("midrst_sp_data",   32'(|sp_data), 32'd0);
    check("midrst_err_cnt",   32'(frame_err_cnt), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    model_frame(8'h05, 8'h12, 8'h34, 8'h23);
    send_frame(40'hA505123423);
    check("postrst_tx_bits", 32'(bus.tx_bits), 32'h06);
    check("postrst_sp_data", 32'(sp_data[5*DATA_W +: DATA_W]), 32'h1234);
    @(posedge clock); #1;
    saw_tx = 1'b0;
    for (int p = 0; p < 3; p++) begin
      pulse_error();
      @(posedge clock); #1;
      if (bus.tx_valid) saw_tx = 1'b1;
    end
    check("idle_err_cnt", 32'(frame_err_cnt), 32'd3);
    check("idle_err_notx", 32'(saw_tx), 32'd0);

    repeat (3) @(posedge clock);
    #1;
    check("tx_queue_drained",  32'(exp_q.size()), 32'd0);
    check("upd_queue_drained", 32'(upd_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
